// File: rtl/pipe_pkg.sv
// Shared types for the decode/execute stage register.
// State encodings and the default bundle width.
package pipe_pkg;

    localparam int PIPE_ID_EXE_W = 154;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit storage register for one bundle entry.
// Async reset, synchronous clear (wins over load), load enable.
module pipe_data_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_ID_EXE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Hold unless cleared or loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Elastic ID/EX stage register: valid/ready with 2-entry skid buffer.
// Optional saturating stall/flush counters under PIPE_STAGE_STATS_EN.
module pipe_stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH         = PIPE_ID_EXE_W,
    parameter bit ZERO_ON_FLUSH = 1'b1,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [1:0]           occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
`endif
);

    pipe_state_e state;
    pipe_state_e state_nxt;

    logic             accept;
    logic             drain;
    logic             main_ld;
    logic             main_sel_skid;
    logic             skid_ld;
    logic             data_clr;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;

    // Handshake flags come straight from the state register.
    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = (state != ST_FULL);
    assign occupancy = state;

    assign accept   = in_valid & in_ready;
    assign drain    = out_valid & out_ready;
    assign data_clr = flush & ZERO_ON_FLUSH;
    assign main_d   = main_sel_skid ? skid_q : in_data;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and register load selects; flush overrides everything.
    always_comb begin
        state_nxt     = state;
        main_ld       = 1'b0;
        main_sel_skid = 1'b0;
        skid_ld       = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                if (accept) begin
                    main_ld   = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    main_ld = 1'b1;
                end else if (accept) begin
                    skid_ld   = 1'b1;
                    state_nxt = ST_FULL;
                end else if (drain) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    main_ld       = 1'b1;
                    main_sel_skid = 1'b1;
                    state_nxt     = ST_ONE;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_nxt = ST_EMPTY;
            main_ld   = 1'b0;
            skid_ld   = 1'b0;
        end
    end

    pipe_data_reg #(
        .WIDTH (WIDTH)
    ) u_main (
        .clk (clk),
        .rst (rst),
        .ld  (main_ld),
        .clr (data_clr),
        .d   (main_d),
        .q   (out_data)
    );

    pipe_data_reg #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk (clk),
        .rst (rst),
        .ld  (skid_ld),
        .clr (data_clr),
        .d   (in_data),
        .q   (skid_q)
    );

`ifdef PIPE_STAGE_STATS_EN
    // Saturating counters for stalled cycles and non-empty flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
            if (flush && (state != ST_EMPTY) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: directed scenarios plus random traffic
// checked against a queue-based FIFO model of the stage.
module tb_pipe_stage_skid_reg;

    localparam int W       = 154;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;
`ifdef PIPE_STAGE_STATS_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
`endif

    pipe_stage_skid_reg #(
        .WIDTH         (W),
        .ZERO_ON_FLUSH (1'b1),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [W-1:0] mq[$];
    logic [W-1:0] exp_main;
    int           stall_m;
    int           flush_m;

    task automatic check(input string tag, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_data();
        return W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_main = '0;
        stall_m  = 0;
        flush_m  = 0;
    endtask

    task automatic model_update();
        bit acc;
        bit drn;
        if (rst) begin
            model_reset();
            return;
        end
        acc = in_valid && (mq.size() < 2);
        drn = (mq.size() > 0) && out_ready;
        if ((mq.size() > 0) && !out_ready && (stall_m < CNT_MAX)) stall_m++;
        if (flush && (mq.size() > 0) && (flush_m < CNT_MAX)) flush_m++;
        if (flush) begin
            mq.delete();
            exp_main = '0;
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back(in_data);
            if (mq.size() > 0) exp_main = mq[0];
        end
    endtask

    task automatic check_all();
        check("out_valid", W'(out_valid), W'(mq.size() > 0));
        check("in_ready", W'(in_ready), W'(mq.size() < 2));
        check("occupancy", W'(occupancy), W'(mq.size()));
        check("out_data", out_data, exp_main);
`ifdef PIPE_STAGE_STATS_EN
        check("stall_cnt", W'(stall_cnt), W'(stall_m));
        check("flush_cnt", W'(flush_cnt), W'(flush_m));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d,
                         input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        model_reset();
        step();
        step();
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_data", out_data, '0);
        rst = 1'b0;

        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, W'('h11 * i), 1'b1, 1'b0);
            step();
            check("stream_data", out_data, W'('h11 * i));
            check("stream_occ", W'(occupancy), W'(1));
            check("stream_rdy", W'(in_ready), W'(1));
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();

        drive(1'b1, W'('hA1), 1'b0, 1'b0);
        step();
        drive(1'b1, W'('hA2), 1'b0, 1'b0);
        step();
        check("bp_occ_full", W'(occupancy), W'(2));
        check("bp_rdy_low", W'(in_ready), W'(0));
        drive(1'b1, W'('hA3), 1'b0, 1'b0);
        step();
        check("bp_a3_held", out_data, W'('hA1));
        check("bp_occ_hold", W'(occupancy), W'(2));
        drive(1'b1, W'('hA3), 1'b1, 1'b0);
        step();
        check("bp_out_a2", out_data, W'('hA2));
        step();
        check("bp_out_a3", out_data, W'('hA3));
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        check("bp_empty", W'(out_valid), W'(0));

        drive(1'b1, W'('hB1), 1'b0, 1'b0);
        step();
        drive(1'b1, W'('hB2), 1'b0, 1'b0);
        step();
        drive(1'b1, W'('hDEAD), 1'b0, 1'b1);
        step();
        check("fl_valid", W'(out_valid), W'(0));
        check("fl_occ", W'(occupancy), W'(0));
        check("fl_data", out_data, '0);
        check("fl_rdy", W'(in_ready), W'(1));
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        check("fl_no_ghost", W'(out_valid), W'(0));

        drive(1'b1, W'('hC1), 1'b0, 1'b0);
        step();
        drive(1'b1, W'('hC2), 1'b0, 1'b0);
        step();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        check("arst_data", out_data, '0);
        check("arst_rdy", W'(in_ready), W'(1));
        step();
        rst = 1'b0;

        drive(1'b1, W'('h55), 1'b0, 1'b0);
        step();
        check("post_rst_55", out_data, W'('h55));
        check("post_rst_vld", W'(out_valid), W'(1));
        drive(1'b0, rnd_data(), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("stall_hold", out_data, W'('h55));
            in_data = rnd_data();
        end
`ifdef PIPE_STAGE_STATS_EN
        check("stall_sat", W'(stall_cnt), W'(15));
`endif
        drive(1'b0, '0, 1'b0, 1'b1);
        step();
`ifdef PIPE_STAGE_STATS_EN
        check("flush_one", W'(flush_cnt), W'(1));
`endif
        drive(1'b0, '0, 1'b0, 1'b0);
        step();

        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), rnd_data(),
                  1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 15) == 0));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
